// File: rtl/umi_data_aggregator_if.sv
// UMI link bundle (cmd/dstaddr/srcaddr/data with valid/ready) shared by
// the aggregator input and output sides.
interface umi_data_aggregator_if #(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 512
);
  logic          valid;
  logic [CW-1:0] cmd;
  logic [AW-1:0] dstaddr;
  logic [AW-1:0] srcaddr;
  logic [DW-1:0] data;
  logic          ready;

  modport master (output valid, cmd, dstaddr, srcaddr, data, input ready);
  modport slave  (input valid, cmd, dstaddr, srcaddr, data, output ready);
endinterface

// File: rtl/umi_data_aggregator.sv
// Coalesces consecutive contiguous mergeable UMI packets into one wide packet
// held in a single buffer; everything else passes through in order.
module umi_data_aggregator #(
  parameter int CW   = 32,
  parameter int AW   = 64,
  parameter int DW   = 512,
  parameter int IDLE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  umi_data_aggregator_if.slave  umi_in,
  umi_data_aggregator_if.master umi_out
);
  localparam int BYTES = DW / 8;
  localparam int NBW   = $clog2(BYTES + 1);
  localparam int IW    = $clog2(IDLE + 1);
  localparam int BW    = 18;
  // len[15:8] and eom[22] may differ between merged beats
  localparam logic [CW-1:0] CMD_MASK = ~CW'(32'h0040_FF00);

  typedef enum logic [1:0] {S_EMPTY, S_OPEN, S_CLOSED} state_t;

  function automatic logic [BW-1:0] pkt_bytes(input logic [CW-1:0] cmd);
    pkt_bytes = (BW'(cmd[15:8]) + BW'(1)) << cmd[7:5];
  endfunction

  function automatic logic is_mergeable(input logic [CW-1:0] cmd);
    is_mergeable = (cmd[4:0] == 5'h02) || (cmd[4:0] == 5'h03) || (cmd[4:0] == 5'h05);
  endfunction

  state_t         r_state, w_next;
  logic [CW-1:0]  r_cmd;
  logic [AW-1:0]  r_dst, r_src;
  logic [DW-1:0]  r_data;
  logic [NBW-1:0] r_nb;
  logic [IW-1:0]  r_idle;

  logic [BW-1:0]  w_in_bytes, w_sum;
  logic           w_can_merge, w_ready, w_accept, w_load, w_merge, w_post_closed;
  logic [DW-1:0]  w_in_masked, w_new_data;
  logic [NBW-1:0] w_new_nb, w_units;
  logic [CW-1:0]  w_new_cmd;

  assign w_in_bytes  = pkt_bytes(umi_in.cmd);
  assign w_sum       = BW'(r_nb) + w_in_bytes;
  assign w_can_merge = (r_state == S_OPEN) && is_mergeable(umi_in.cmd)
                    && ((umi_in.cmd & CMD_MASK) == (r_cmd & CMD_MASK))
                    && (umi_in.dstaddr == (r_dst + AW'(r_nb)))
                    && (umi_in.srcaddr == (r_src + AW'(r_nb)))
                    && (w_sum <= BW'(BYTES));
  assign w_ready  = !reset && ((r_state == S_EMPTY) || w_can_merge
                            || ((r_state == S_CLOSED) && umi_out.ready));
  assign w_accept = umi_in.valid && w_ready;
  assign w_load   = w_accept && (r_state != S_OPEN);
  assign w_merge  = w_accept && (r_state == S_OPEN);

  always_comb begin
    w_in_masked = '0;
    for (int i = 0; i < BYTES; i++)
      w_in_masked[8*i +: 8] = (BW'(i) < w_in_bytes) ? umi_in.data[8*i +: 8] : 8'h00;
  end

  // Buffer bytes at and above nb are always zero, so OR places the new beat
  assign w_new_data = w_load ? w_in_masked : (r_data | (w_in_masked << {r_nb, 3'b000}));
  assign w_new_nb   = w_load ? w_in_bytes[NBW-1:0] : w_sum[NBW-1:0];
  assign w_units    = w_sum[NBW-1:0] >> r_cmd[7:5];

  always_comb begin
    w_new_cmd = umi_in.cmd;
    if (!w_load) begin
      w_new_cmd        = r_cmd;
      w_new_cmd[15:8]  = 8'(w_units) - 8'd1;
      w_new_cmd[22]    = umi_in.cmd[22];
    end
  end

  assign w_post_closed = !is_mergeable(w_new_cmd) || w_new_cmd[22] || (w_new_nb == NBW'(BYTES));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_EMPTY:  if (w_load) w_next = w_post_closed ? S_CLOSED : S_OPEN;
      S_OPEN: begin
        if (w_merge)                          w_next = w_post_closed ? S_CLOSED : S_OPEN;
        else if (umi_in.valid)                w_next = S_CLOSED;
        else if (32'(r_idle) + 1 >= IDLE)     w_next = S_CLOSED;
      end
      S_CLOSED: if (umi_out.ready) w_next = w_load ? (w_post_closed ? S_CLOSED : S_OPEN) : S_EMPTY;
      default:  w_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd  <= '0;
      r_dst  <= '0;
      r_src  <= '0;
      r_data <= '0;
      r_nb   <= '0;
      r_idle <= '0;
    end else begin
      if (w_accept) begin
        r_cmd  <= w_new_cmd;
        r_data <= w_new_data;
        r_nb   <= w_new_nb;
        if (w_load) begin
          r_dst <= umi_in.dstaddr;
          r_src <= umi_in.srcaddr;
        end
      end
      if ((r_state == S_OPEN) && !umi_in.valid) r_idle <= r_idle + IW'(1);
      else                                       r_idle <= '0;
    end
  end

  assign umi_in.ready     = w_ready;
  assign umi_out.valid    = (r_state == S_CLOSED);
  assign umi_out.cmd      = r_cmd;
  assign umi_out.dstaddr  = r_dst;
  assign umi_out.srcaddr  = r_src;
  assign umi_out.data     = r_data;
endmodule

// File: tb/tb_umi_data_aggregator.sv
// Directed bench for umi_data_aggregator: merge, fill, split, pass-through,
// idle close, backpressure byte-stream model and reset discard.
module tb_umi_data_aggregator;
  localparam int CW = 32, AW = 64, DW = 512, IDLE = 4, BYTES = DW / 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  umi_data_aggregator_if #(.CW(CW), .AW(AW), .DW(DW)) in_if ();
  umi_data_aggregator_if #(.CW(CW), .AW(AW), .DW(DW)) out_if ();

  umi_data_aggregator #(.CW(CW), .AW(AW), .DW(DW), .IDLE(IDLE)) dut (
    .clk(clk), .reset(reset), .umi_in(in_if), .umi_out(out_if)
  );

  int n_chk = 0, n_bad = 0;
  int cyc = 0, acc_cyc = 0, out_cyc = 0;
  bit g_acc, g_out_vld, g_toggle = 0;
  logic [CW-1:0] q_cmd[$];
  logic [AW-1:0] q_dst[$], q_src[$];
  logic [DW-1:0] q_data[$];
  logic [7:0]    mb[$];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk_cmd(input logic [4:0] op, input logic [2:0] sz,
                                           input logic [7:0] len, input logic eom);
    logic [CW-1:0] c;
    c = '0; c[4:0] = op; c[7:5] = sz; c[15:8] = len; c[22] = eom;
    return c;
  endfunction

  function automatic logic [DW-1:0] pat(input logic [7:0] b0, input int n, input logic [7:0] fill);
    logic [DW-1:0] r;
    for (int i = 0; i < BYTES; i++) r[8*i +: 8] = (i < n) ? b0 + 8'(i) : fill;
    return r;
  endfunction

  // one clock: sample handshakes 1 time unit before the rising edge
  task automatic tick();
    #4;
    g_acc     = in_if.valid && in_if.ready;
    g_out_vld = out_if.valid;
    if (g_acc) acc_cyc = cyc;
    if (out_if.valid && out_if.ready) begin
      q_cmd.push_back(out_if.cmd);
      q_dst.push_back(out_if.dstaddr);
      q_src.push_back(out_if.srcaddr);
      q_data.push_back(out_if.data);
      out_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
    if (g_toggle) out_if.ready = ~out_if.ready;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [CW-1:0] c, input logic [AW-1:0] d, input logic [AW-1:0] s,
                      input logic [DW-1:0] dat);
    int n;
    n = 0;
    in_if.valid = 1'b1; in_if.cmd = c; in_if.dstaddr = d; in_if.srcaddr = s; in_if.data = dat;
    g_acc = 1'b0;
    while (!g_acc && n < 100) begin
      tick();
      n++;
    end
    if (!g_acc) check("send_timeout", DW'(g_acc), DW'(1));
    in_if.valid = 1'b0;
  endtask

  task automatic wait_outs(input int k);
    int n;
    n = 0;
    while (q_cmd.size() < k && n < 50) begin
      tick();
      n++;
    end
    if (q_cmd.size() < k) check("wait_out", DW'(q_cmd.size()), DW'(k));
  endtask

  task automatic exp_pkt(input string tag, input int idx, input logic [CW-1:0] c,
                         input logic [AW-1:0] d, input logic [AW-1:0] s, input logic [DW-1:0] dat);
    if (idx >= q_cmd.size()) check({tag, "_missing"}, DW'(q_cmd.size()), DW'(idx + 1));
    else begin
      check({tag, "_cmd"}, DW'(q_cmd[idx]), DW'(c));
      check({tag, "_dst"}, DW'(q_dst[idx]), DW'(d));
      check({tag, "_src"}, DW'(q_src[idx]), DW'(s));
      check({tag, "_data"}, q_data[idx], dat);
    end
  endtask

  initial begin
    int n0, pos, nb, total, len;
    logic eom;
    logic [DW-1:0] ed, dat;

    reset = 1'b1;
    in_if.valid = 1'b1; in_if.cmd = mk_cmd(5'h03, 3'd0, 8'd7, 1'b0);
    in_if.dstaddr = '0; in_if.srcaddr = '0; in_if.data = '1;
    out_if.ready = 1'b1;
    @(negedge clk);
    #4;
    check("rst_out_valid", DW'(out_if.valid), DW'(0));
    check("rst_in_ready", DW'(in_if.ready), DW'(0));
    check("rst_out_cmd", DW'(out_if.cmd), DW'(0));
    check("rst_out_dst", DW'(out_if.dstaddr), DW'(0));
    check("rst_out_data", out_if.data, DW'(0));
    @(negedge clk);
    in_if.valid = 1'b0; reset = 1'b0;
    tick();
    check("empty_ready", DW'(in_if.ready), DW'(1));

    // contiguous write pair
    n0 = q_cmd.size();
    send(mk_cmd(5'h03, 3'd0, 8'd7, 1'b0), 64'h100, 64'h200, pat(8'h00, 8, 8'hEE));
    send(mk_cmd(5'h03, 3'd0, 8'd7, 1'b1), 64'h108, 64'h208, pat(8'h10, 8, 8'hEE));
    tick();
    check("pair_count", DW'(q_cmd.size()), DW'(n0 + 1));
    check("pair_latency", DW'(out_cyc - acc_cyc), DW'(1));
    ed = pat(8'h00, 8, 8'h00) | (pat(8'h10, 8, 8'h00) << 64);
    exp_pkt("pair", n0, mk_cmd(5'h03, 3'd0, 8'd15, 1'b1), 64'h100, 64'h200, ed);

    // eight 8-byte posted writes fill the buffer
    n0 = q_cmd.size();
    for (int j = 0; j < 8; j++)
      send(mk_cmd(5'h05, 3'd0, 8'd7, 1'b0), AW'(8 * j), AW'(64'h1000 + 8 * j), pat(8'(8 * j), 8, 8'hEE));
    tick();
    check("fill_count", DW'(q_cmd.size()), DW'(n0 + 1));
    check("fill_latency", DW'(out_cyc - acc_cyc), DW'(1));
    exp_pkt("fill", n0, mk_cmd(5'h05, 3'd0, 8'd63, 1'b0), 64'h0, 64'h1000, pat(8'h00, 64, 8'h00));

    // non-contiguous: second write closes the first and loads on its handshake
    n0 = q_cmd.size();
    send(mk_cmd(5'h03, 3'd0, 8'd7, 1'b0), 64'h100, 64'h300, pat(8'h20, 8, 8'hEE));
    send(mk_cmd(5'h03, 3'd0, 8'd7, 1'b0), 64'h200, 64'h400, pat(8'h30, 8, 8'hEE));
    check("nc_accept_on_out", DW'(acc_cyc), DW'(out_cyc));
    wait_outs(n0 + 2);
    exp_pkt("nc_a", n0, mk_cmd(5'h03, 3'd0, 8'd7, 1'b0), 64'h100, 64'h300, pat(8'h20, 8, 8'h00));
    exp_pkt("nc_b", n0 + 1, mk_cmd(5'h03, 3'd0, 8'd7, 1'b0), 64'h200, 64'h400, pat(8'h30, 8, 8'h00));

    // read passes through and splits a contiguous write run
    n0 = q_cmd.size();
    send(mk_cmd(5'h03, 3'd0, 8'd7, 1'b0), 64'h500, 64'h600, pat(8'h40, 8, 8'hEE));
    send(mk_cmd(5'h01, 3'd0, 8'd3, 1'b0), 64'h900, 64'hA00, pat(8'h77, 4, 8'h00));
    send(mk_cmd(5'h03, 3'd0, 8'd7, 1'b0), 64'h508, 64'h608, pat(8'h48, 8, 8'hEE));
    wait_outs(n0 + 3);
    exp_pkt("pt_w1", n0, mk_cmd(5'h03, 3'd0, 8'd7, 1'b0), 64'h500, 64'h600, pat(8'h40, 8, 8'h00));
    exp_pkt("pt_rd", n0 + 1, mk_cmd(5'h01, 3'd0, 8'd3, 1'b0), 64'h900, 64'hA00, pat(8'h77, 4, 8'h00));
    exp_pkt("pt_w2", n0 + 2, mk_cmd(5'h03, 3'd0, 8'd7, 1'b0), 64'h508, 64'h608, pat(8'h48, 8, 8'h00));

    // idle close
    idle(3);
    n0 = q_cmd.size();
    send(mk_cmd(5'h03, 3'd0, 8'd7, 1'b0), 64'h700, 64'h800, pat(8'h50, 8, 8'hEE));
    wait_outs(n0 + 1);
    check("idle_latency", DW'(out_cyc - acc_cyc), DW'(IDLE + 1));
    exp_pkt("idle", n0, mk_cmd(5'h03, 3'd0, 8'd7, 1'b0), 64'h700, 64'h800, pat(8'h50, 8, 8'h00));

    // backpressure: toggling out_ready over 32 random contiguous writes
    idle(2);
    n0 = q_cmd.size();
    total = 0;
    g_toggle = 1;
    for (int p = 0; p < 32; p++) begin
      len = $urandom_range(0, 15);
      eom = (p == 31) ? 1'b1 : ($urandom_range(0, 3) == 0);
      dat = '1;
      for (int b = 0; b <= len; b++) begin
        dat[8*b +: 8] = 8'($urandom_range(0, 255));
        mb.push_back(dat[8*b +: 8]);
      end
      send(mk_cmd(5'h03, 3'd0, 8'(len), eom), AW'(64'h4000 + total), AW'(64'h9000 + total), dat);
      total += len + 1;
    end
    idle(20);
    g_toggle = 0;
    out_if.ready = 1'b1;
    pos = 0;
    for (int k = n0; k < q_cmd.size(); k++) begin
      nb = (int'(q_cmd[k][15:8]) + 1) << q_cmd[k][7:5];
      ed = '0;
      for (int i = 0; i < nb && i < BYTES; i++)
        if (pos + i < mb.size()) ed[8*i +: 8] = mb[pos + i];
      check("bp_op", DW'(q_cmd[k][4:0]), DW'(3));
      check("bp_dst", DW'(q_dst[k]), DW'(64'h4000 + pos));
      check("bp_src", DW'(q_src[k]), DW'(64'h9000 + pos));
      check("bp_data", q_data[k], ed);
      pos += nb;
    end
    check("bp_total_bytes", DW'(pos), DW'(total));

    // reset while a closed packet is held back, then while a packet is open
    out_if.ready = 1'b0;
    n0 = q_cmd.size();
    send(mk_cmd(5'h03, 3'd0, 8'd7, 1'b1), 64'hB00, 64'hC00, pat(8'h60, 8, 8'hEE));
    tick();
    check("rst_pre_valid", DW'(g_out_vld), DW'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rst_mid_valid", DW'(g_out_vld), DW'(0));
    out_if.ready = 1'b1;
    send(mk_cmd(5'h03, 3'd0, 8'd7, 1'b0), 64'hD00, 64'hE00, pat(8'h70, 8, 8'hEE));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(10);
    check("rst_no_emit", DW'(q_cmd.size()), DW'(n0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
